// File: rtl/mmio_bridge_pkg.sv
// Shared types and defaults for the MMIO-to-slot bridge.
// Holds the FSM state encoding and the wait-counter width helper.
package mmio_bridge_pkg;

    localparam int DEF_ADDR_W         = 21;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_REG_ADDR_W     = 5;
    localparam int DEF_SLOT_ADDR_W    = 6;
    localparam int DEF_N_SLOTS        = 64;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int cnt_width(input int timeout_cycles);
        return $clog2(timeout_cycles) + 1;
    endfunction

endpackage

// File: rtl/mmio_slot_decoder.sv
// Combinational slot decode: one-hot strobe, in-range flag, and the
// per-slot acknowledge/read-data selection for the addressed slot.
module mmio_slot_decoder #(
    parameter int SLOT_ADDR_W = 6,
    parameter int DATA_W      = 32,
    parameter int N_SLOTS     = 64
) (
    input  logic [SLOT_ADDR_W-1:0]         slot,
    input  logic                           enable,
    input  logic [N_SLOTS-1:0]             ack_array,
    input  logic [N_SLOTS-1:0][DATA_W-1:0] rdata_array,
    output logic [N_SLOTS-1:0]             cs_array,
    output logic                           in_range,
    output logic                           ack,
    output logic [DATA_W-1:0]              rdata
);

    // The extra bit lets N_SLOTS equal 2**SLOT_ADDR_W without overflow.
    localparam logic [SLOT_ADDR_W:0] SLOT_LIMIT = (SLOT_ADDR_W + 1)'(N_SLOTS);

    // Decode the slot index and select that slot's ack and read data.
    always_comb begin
        in_range = ({1'b0, slot} < SLOT_LIMIT);
        cs_array = '0;
        ack      = 1'b0;
        rdata    = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if ({1'b0, slot} == (SLOT_ADDR_W + 1)'(i)) begin
                cs_array[i] = enable;
                ack         = ack_array[i];
                rdata       = rdata_array[i];
            end else begin
                cs_array[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mmio_slot_bridge.sv
// Registered MMIO-to-slot bridge: decodes slot/register fields, strobes one
// slot, waits for its acknowledge with a timeout and returns data or an error.
module mmio_slot_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
    parameter int SLOT_ADDR_W    = DEF_SLOT_ADDR_W,
    parameter int N_SLOTS        = DEF_N_SLOTS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mmio_cs,
    input  logic                           mmio_read,
    input  logic                           mmio_write,
    input  logic [ADDR_W-1:0]              mmio_addr,
    input  logic [DATA_W-1:0]              mmio_write_data,
    output logic [DATA_W-1:0]              mmio_read_data,
    output logic                           mmio_ready,
    output logic                           mmio_error,
    output logic                           mmio_busy,
    output logic                           overrun,
    output logic [N_SLOTS-1:0]             slot_cs_array,
    output logic                           slot_read,
    output logic                           slot_write,
    output logic [DATA_W-1:0]              slot_write_data,
    output logic [REG_ADDR_W-1:0]          slot_reg_addr,
    input  logic [N_SLOTS-1:0]             slot_ack_array,
    input  logic [N_SLOTS-1:0][DATA_W-1:0] slot_read_data_array
);

    localparam int               CNT_W    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [CNT_W-1:0]         cnt_r;
    logic [SLOT_ADDR_W-1:0]   slot_r;
    logic                     rd_r;
    logic [SLOT_ADDR_W-1:0]   addr_slot_s;
    logic [SLOT_ADDR_W-1:0]   dec_slot_s;
    logic                     dec_en_s;
    logic                     req_valid_s;
    logic                     accept_s;
    logic                     err_nxt_s;
    logic [DATA_W-1:0]        rdata_nxt_s;
    logic [N_SLOTS-1:0]       dec_cs_s;
    logic                     in_range_s;
    logic                     ack_s;
    logic [DATA_W-1:0]        sel_data_s;
    logic                     unused_addr_s;

    assign addr_slot_s   = mmio_addr[REG_ADDR_W +: SLOT_ADDR_W];
    assign unused_addr_s = ^mmio_addr[ADDR_W-1:REG_ADDR_W+SLOT_ADDR_W];
    assign req_valid_s   = mmio_read ^ mmio_write;
    // While idle the decoder looks at the incoming address, afterwards at the captured slot.
    assign dec_slot_s    = (state_r == IDLE) ? addr_slot_s : slot_r;
    assign dec_en_s      = (state_r == IDLE) & mmio_cs & req_valid_s;
    assign accept_s      = (state_r == IDLE) && (state_nxt_s == ISSUE);

    mmio_slot_decoder #(
        .SLOT_ADDR_W (SLOT_ADDR_W),
        .DATA_W      (DATA_W),
        .N_SLOTS     (N_SLOTS)
    ) u_decoder (
        .slot        (dec_slot_s),
        .enable      (dec_en_s),
        .ack_array   (slot_ack_array),
        .rdata_array (slot_read_data_array),
        .cs_array    (dec_cs_s),
        .in_range    (in_range_s),
        .ack         (ack_s),
        .rdata       (sel_data_s)
    );

    // Next-state, completion status and completion data.
    always_comb begin
        state_nxt_s = state_r;
        err_nxt_s   = 1'b0;
        rdata_nxt_s = '0;
        case (state_r)
            IDLE: begin
                if (mmio_cs) begin
                    if (req_valid_s && in_range_s) begin
                        state_nxt_s = ISSUE;
                    end else begin
                        state_nxt_s = DONE;
                        err_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE, WAIT: begin
                if (ack_s) begin
                    state_nxt_s = DONE;
                    rdata_nxt_s = rd_r ? sel_data_s : '0;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = DONE;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counter, capture registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            cnt_r           <= '0;
            slot_r          <= '0;
            rd_r            <= 1'b0;
            mmio_read_data  <= '0;
            mmio_ready      <= 1'b0;
            mmio_error      <= 1'b0;
            mmio_busy       <= 1'b0;
            overrun         <= 1'b0;
            slot_cs_array   <= '0;
            slot_read       <= 1'b0;
            slot_write      <= 1'b0;
            slot_write_data <= '0;
            slot_reg_addr   <= '0;
        end else begin
            state_r        <= state_nxt_s;
            mmio_busy      <= (state_nxt_s != IDLE);
            mmio_ready     <= (state_nxt_s == DONE);
            mmio_error     <= err_nxt_s;
            mmio_read_data <= (state_nxt_s == DONE) ? rdata_nxt_s : '0;
            overrun        <= overrun | (mmio_cs & (state_r != IDLE));
            slot_cs_array  <= accept_s ? dec_cs_s : '0;
            slot_read      <= accept_s & mmio_read;
            slot_write     <= accept_s & mmio_write;
            if (accept_s) begin
                cnt_r           <= '0;
                slot_r          <= addr_slot_s;
                rd_r            <= mmio_read;
                slot_reg_addr   <= mmio_addr[REG_ADDR_W-1:0];
                slot_write_data <= mmio_write_data;
            end else if (state_r == ISSUE || state_r == WAIT) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mmio_slot_bridge.sv
// Self-checking bench for mmio_slot_bridge: directed transactions plus a
// per-cycle transaction-level model of when and how each request completes.
module tb_mmio_slot_bridge;

    localparam int ADDR_W      = 21;
    localparam int DATA_W      = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int SLOT_ADDR_W = 6;
    localparam int N_SLOTS     = 40;
    localparam int TIMEOUT     = 16;

    logic                           clk = 1'b0;
    logic                           reset;
    logic                           mmio_cs;
    logic                           mmio_read;
    logic                           mmio_write;
    logic [ADDR_W-1:0]              mmio_addr;
    logic [DATA_W-1:0]              mmio_write_data;
    logic [DATA_W-1:0]              mmio_read_data;
    logic                           mmio_ready;
    logic                           mmio_error;
    logic                           mmio_busy;
    logic                           overrun;
    logic [N_SLOTS-1:0]             slot_cs_array;
    logic                           slot_read;
    logic                           slot_write;
    logic [DATA_W-1:0]              slot_write_data;
    logic [REG_ADDR_W-1:0]          slot_reg_addr;
    logic [N_SLOTS-1:0]             slot_ack_array;
    logic [N_SLOTS-1:0][DATA_W-1:0] slot_read_data_array;

    int n_checks = 0;
    int n_pass   = 0;

    mmio_slot_bridge #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .REG_ADDR_W     (REG_ADDR_W),
        .SLOT_ADDR_W    (SLOT_ADDR_W),
        .N_SLOTS        (N_SLOTS),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .mmio_cs              (mmio_cs),
        .mmio_read            (mmio_read),
        .mmio_write           (mmio_write),
        .mmio_addr            (mmio_addr),
        .mmio_write_data      (mmio_write_data),
        .mmio_read_data       (mmio_read_data),
        .mmio_ready           (mmio_ready),
        .mmio_error           (mmio_error),
        .mmio_busy            (mmio_busy),
        .overrun              (overrun),
        .slot_cs_array        (slot_cs_array),
        .slot_read            (slot_read),
        .slot_write           (slot_write),
        .slot_write_data      (slot_write_data),
        .slot_reg_addr        (slot_reg_addr),
        .slot_ack_array       (slot_ack_array),
        .slot_read_data_array (slot_read_data_array)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic rd, input logic wr, input int slot, input int rg,
                           input logic [DATA_W-1:0] wdata);
        mmio_cs         = 1'b1;
        mmio_read       = rd;
        mmio_write      = wr;
        mmio_addr       = ADDR_W'((slot << REG_ADDR_W) | rg);
        mmio_write_data = wdata;
    endtask

    task automatic idle_bus();
        mmio_cs    = 1'b0;
        mmio_read  = 1'b0;
        mmio_write = 1'b0;
    endtask

    // Transaction-level model: one outstanding request, completion time decided by
    // the first observed ack of the addressed slot or by the timeout.
    int                 cyc = 0;
    bit                 m_active = 1'b0;
    bit                 m_resolved = 1'b0;
    bit                 m_issue = 1'b0;
    bit                 m_rd = 1'b0;
    bit                 m_err = 1'b0;
    bit                 m_ovr = 1'b0;
    int                 m_tacc = 0;
    int                 m_tdone = 0;
    int                 m_slot = 0;
    logic [DATA_W-1:0]  m_data = '0;
    logic [DATA_W-1:0]  m_wdata = '0;
    logic [REG_ADDR_W-1:0] m_reg = '0;

    initial begin
        bit                busy_e;
        bit                ready_e;
        bit                issue_e;
        logic [N_SLOTS-1:0] cs_e;
        int                slot;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            busy_e  = m_active && (cyc > m_tacc);
            ready_e = m_active && m_resolved && (cyc == m_tdone);
            issue_e = m_active && m_issue && (cyc == m_tacc + 1);
            cs_e    = '0;
            if (issue_e) cs_e[m_slot] = 1'b1;

            chk("busy", mmio_busy, busy_e);
            chk("ready", mmio_ready, ready_e);
            chk("error", mmio_error, ready_e & m_err);
            chk("read_data", mmio_read_data, ready_e ? m_data : '0);
            chk("overrun", overrun, m_ovr);
            chk("slot_cs", slot_cs_array, cs_e);
            chk("slot_read", slot_read, issue_e & m_rd);
            chk("slot_write", slot_write, issue_e & !m_rd);
            if (busy_e && m_issue) begin
                chk("slot_reg_addr", slot_reg_addr, m_reg);
                if (!m_rd) chk("slot_write_data", slot_write_data, m_wdata);
            end

            if (reset) begin
                m_active = 1'b0;
                m_ovr    = 1'b0;
            end else begin
                if (m_active && !m_resolved && cyc > m_tacc) begin
                    if (slot_ack_array[m_slot]) begin
                        m_resolved = 1'b1;
                        m_tdone    = cyc + 1;
                        m_err      = 1'b0;
                        m_data     = m_rd ? slot_read_data_array[m_slot] : '0;
                    end else if (cyc == m_tacc + TIMEOUT) begin
                        m_resolved = 1'b1;
                        m_tdone    = cyc + 1;
                        m_err      = 1'b1;
                        m_data     = '0;
                    end
                end
                if (m_active && m_resolved && cyc == m_tdone) m_active = 1'b0;
                if (mmio_cs) begin
                    if (busy_e) begin
                        m_ovr = 1'b1;
                    end else begin
                        slot     = int'(mmio_addr >> REG_ADDR_W) % (1 << SLOT_ADDR_W);
                        m_active = 1'b1;
                        m_tacc   = cyc;
                        m_rd     = mmio_read;
                        m_issue  = (mmio_read != mmio_write) && (slot < N_SLOTS);
                        m_slot   = slot;
                        m_reg    = mmio_addr[REG_ADDR_W-1:0];
                        m_wdata  = mmio_write_data;
                        if (m_issue) begin
                            m_resolved = 1'b0;
                        end else begin
                            m_resolved = 1'b1;
                            m_tdone    = cyc + 1;
                            m_err      = 1'b1;
                            m_data     = '0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        mmio_cs         = 1'b0;
        mmio_read       = 1'b0;
        mmio_write      = 1'b0;
        mmio_addr       = '0;
        mmio_write_data = '0;
        slot_ack_array  = '0;
        for (int i = 0; i < N_SLOTS; i++) slot_read_data_array[i] = 32'hCAFE_0000 | DATA_W'(i);
        repeat (3) cycle();
        chk("reset_busy", mmio_busy, 1'b0);
        chk("reset_ready", mmio_ready, 1'b0);
        chk("reset_cs", slot_cs_array, '0);
        reset = 1'b0;
        cycle();

        // Read slot 3 reg 7, acked in ISSUE.
        request(1'b1, 1'b0, 3, 7, 32'h0);
        cycle();
        idle_bus();
        chk("t1_cs", slot_cs_array, 64'h8);
        chk("t1_slot_read", slot_read, 1'b1);
        chk("t1_reg", slot_reg_addr, 5'd7);
        slot_ack_array[3] = 1'b1;
        cycle();
        slot_ack_array[3] = 1'b0;
        chk("t1_ready", mmio_ready, 1'b1);
        chk("t1_data", mmio_read_data, 32'hCAFE_0003);
        chk("t1_err", mmio_error, 1'b0);
        chk("t1_cs_off", slot_cs_array, '0);
        cycle();
        chk("t1_ready_off", mmio_ready, 1'b0);
        chk("t1_busy_off", mmio_busy, 1'b0);

        // Write slot 10 reg 0, ack four cycles after ISSUE.
        request(1'b0, 1'b1, 10, 0, 32'h1234_5678);
        cycle();
        idle_bus();
        chk("t2_slot_write", slot_write, 1'b1);
        repeat (2) cycle();
        chk("t2_wdata_hold", slot_write_data, 32'h1234_5678);
        chk("t2_write_once", slot_write, 1'b0);
        repeat (2) cycle();
        slot_ack_array[10] = 1'b1;
        cycle();
        slot_ack_array[10] = 1'b0;
        chk("t2_ready", mmio_ready, 1'b1);
        chk("t2_err", mmio_error, 1'b0);
        chk("t2_data", mmio_read_data, 32'h0);
        cycle();

        // Read slot 5 never acked; slot 6 acks spuriously.
        request(1'b1, 1'b0, 5, 1, 32'h0);
        cycle();
        idle_bus();
        for (int k = 1; k <= TIMEOUT; k++) begin
            slot_ack_array[6] = (k <= 5);
            if (k == TIMEOUT) chk("t3_not_yet", mmio_ready, 1'b0);
            cycle();
        end
        slot_ack_array[6] = 1'b0;
        chk("t3_ready", mmio_ready, 1'b1);
        chk("t3_err", mmio_error, 1'b1);
        chk("t3_data", mmio_read_data, 32'h0);
        cycle();

        // Unmapped slot 45, then read+write together on slot 2.
        request(1'b1, 1'b0, 45, 0, 32'h0);
        cycle();
        idle_bus();
        chk("t4_ready", mmio_ready, 1'b1);
        chk("t4_err", mmio_error, 1'b1);
        chk("t4_cs", slot_cs_array, '0);
        cycle();
        request(1'b1, 1'b1, 2, 0, 32'h0);
        cycle();
        idle_bus();
        chk("t4b_ready", mmio_ready, 1'b1);
        chk("t4b_err", mmio_error, 1'b1);
        chk("t4b_read", slot_read, 1'b0);
        cycle();

        // Second request during WAIT is dropped and flags overrun.
        request(1'b1, 1'b0, 3, 1, 32'h0);
        cycle();
        idle_bus();
        cycle();
        request(1'b0, 1'b1, 4, 0, 32'hDEAD_BEEF);
        cycle();
        idle_bus();
        chk("t5_overrun", overrun, 1'b1);
        slot_ack_array[3] = 1'b1;
        cycle();
        slot_ack_array[3] = 1'b0;
        chk("t5_ready", mmio_ready, 1'b1);
        chk("t5_data", mmio_read_data, 32'hCAFE_0003);
        repeat (3) cycle();
        chk("t5_sticky", overrun, 1'b1);

        // Reset in WAIT with a pending ack, then a normal request.
        request(1'b1, 1'b0, 7, 0, 32'h0);
        cycle();
        idle_bus();
        repeat (2) cycle();
        reset = 1'b1;
        slot_ack_array[7] = 1'b1;
        cycle();
        reset = 1'b0;
        slot_ack_array[7] = 1'b0;
        chk("t6_busy", mmio_busy, 1'b0);
        chk("t6_ready", mmio_ready, 1'b0);
        chk("t6_overrun", overrun, 1'b0);
        chk("t6_reg", slot_reg_addr, 5'd0);
        chk("t6_wdata", slot_write_data, 32'h0);
        request(1'b1, 1'b0, 1, 2, 32'h0);
        cycle();
        idle_bus();
        chk("t6_cs", slot_cs_array, 64'h2);
        slot_ack_array[1] = 1'b1;
        cycle();
        slot_ack_array[1] = 1'b0;
        chk("t6_ready2", mmio_ready, 1'b1);
        chk("t6_data", mmio_read_data, 32'hCAFE_0001);
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_slot_bridge.md
Name: mmio_slot_bridge

Overview:
- Parametrised, registered MMIO-to-slot bridge; successor to the flat combinational slot decoder.
- Sits between the MCS I/O bus and N peripheral slots.
- Decodes slot/register fields, issues a one-cycle slot strobe and waits for a per-slot acknowledge.
- Returns read data with a ready pulse; flags unmapped-slot, protocol and timeout errors.

Parameters:
- ADDR_W, 21: MMIO address width.
- DATA_W, 32: data width.
- REG_ADDR_W, 5: register field width (low address bits).
- SLOT_ADDR_W, 6: slot field width. Constraint: N_SLOTS <= 2**SLOT_ADDR_W.
- N_SLOTS, 64: number of implemented slots.
- TIMEOUT_CYCLES, 16: maximum cycles to wait for a slot ack. Constraint: >= 1, <= 256.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mmio_cs  in  1  request valid.
- mmio_read  in  1  read request.
- mmio_write  in  1  write request.
- mmio_addr  in  ADDR_W  byte-independent word address.
- mmio_write_data  in  DATA_W  write data.
- mmio_read_data  out  DATA_W  read data; valid while mmio_ready=1.
- mmio_ready  out  1  one-cycle completion pulse.
- mmio_error  out  1  qualifies mmio_ready: the transaction failed.
- mmio_busy  out  1  bridge not idle.
- overrun  out  1  sticky: a request arrived while busy; cleared only by reset.
- slot_cs_array  out  N_SLOTS  one-hot slot strobe.
- slot_read  out  1  broadcast read strobe.
- slot_write  out  1  broadcast write strobe.
- slot_write_data  out  DATA_W  broadcast, registered write data.
- slot_reg_addr  out  REG_ADDR_W  broadcast, registered register address.
- slot_ack_array  in  N_SLOTS  per-slot acknowledge.
- slot_read_data_array  in  [N_SLOTS][DATA_W]  per-slot read data.

Behaviour:
- Address fields: reg = mmio_addr[REG_ADDR_W-1:0]; slot = mmio_addr[REG_ADDR_W +: SLOT_ADDR_W]. Upper bits are ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, mmio_cs=1 with exactly one of read/write set, in cycle t:
  - Capture slot, reg, data and direction.
  - If slot < N_SLOTS, go to ISSUE; otherwise go to DONE with err=1.
- IDLE, mmio_cs=1 with read=write=1 or read=write=0: go to DONE with err=1; no slot is touched.
- ISSUE (cycle t+1):
  - Drive slot_cs_array[slot]=1 and slot_read or slot_write=1 for this cycle only.
  - slot_reg_addr and slot_write_data hold their captured values from ISSUE until IDLE.
- Acknowledge handling (ISSUE or WAIT):
  - Only slot_ack_array[slot] is observed; acks from other slots are ignored.
  - Ack seen: capture slot_read_data_array[slot] (reads only; writes capture 0), go to DONE with err=0.
  - No ack: increment the wait counter (reset to 0 on entry to ISSUE) and go to or stay in WAIT.
  - If the counter reaches TIMEOUT_CYCLES-1 without ack: go to DONE with err=1, read data 0.
- DONE: mmio_ready=1 and mmio_error=err for one cycle, then IDLE.
- Latencies:
  - Best case is a same-cycle ack in ISSUE: ready at t+2.
  - Timeout: ready at t+1+TIMEOUT_CYCLES.
  - Unmapped slot or protocol error: ready at t+1.
- mmio_read_data: 0 whenever mmio_ready=0.
- mmio_busy: 1 in ISSUE, WAIT and DONE.
- mmio_cs=1 while busy: request dropped, overrun set; the current transaction is unaffected.
- Back-to-back: a new request is accepted in the cycle after DONE, i.e. IDLE.
- Reset, including mid-transaction:
  - Next edge: state=IDLE, counter=0, overrun=0.
  - All outputs 0: slot strobes, slot_cs_array, mmio_ready, mmio_error, mmio_read_data, slot_write_data, slot_reg_addr.
  - Any pending ack is discarded.

Decomposition:
- Package mmio_bridge_pkg holds:
  - the state_t enum (IDLE, ISSUE, WAIT, DONE);
  - the localparam function computing the counter width, $clog2(TIMEOUT_CYCLES)+1;
  - default parameter constants.
- One natural sub-module, mmio_slot_decoder: purely combinational. Maps slot index + enable to one-hot slot_cs_array and an in-range flag; also muxes ack and read data.
- FSM, counter and capture registers stay in mmio_slot_bridge.

Test Plan:
- Read slot 3, reg 7 (addr 0x67); slot 3 acks in ISSUE with data 0xCAFE_0003 -> slot_cs_array[3] for exactly one cycle, slot_reg_addr=7, mmio_ready at t+2, data 0xCAFE_0003, error 0.
- Write 0x1234_5678 to slot 10, reg 0; ack delayed 4 cycles -> slot_write pulses once, slot_write_data stable through WAIT, ready at t+6, error 0.
- Read slot 5 (TIMEOUT_CYCLES=16); no ack, slot 6 acks spuriously -> ready at t+17, error 1, data 0.
- N_SLOTS=40, read slot 45 -> no slot strobe, ready at t+1, error 1; also read=write=1 on slot 2 -> same response.
- Second mmio_cs during WAIT -> dropped, overrun=1 and sticky, first transaction completes normally.
- Reset asserted in WAIT -> next cycle busy=0, all strobes and outputs 0; request at the following cycle accepted normally.
